// File: rtl/dmem_if.sv
// Core data-port bundle between the core (master) and the data-memory responder (slave).
interface dmem_if;
   logic        rd_en;
   logic [31:0] rd_addr;
   logic        is_mem_write;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        stop;

   modport master (
      output rd_en, rd_addr, is_mem_write, wr_addr, wr_data,
      input  rd_data, rd_valid, stop
   );

   modport slave (
      input  rd_en, rd_addr, is_mem_write, wr_addr, wr_data,
      output rd_data, rd_valid, stop
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single-port word RAM behind a posted-store FIFO with load forwarding.
// Define DMEM_STARVE_GUARD_EN to force a drain after STARVE_LIMIT load-blocked cycles.
module dmem_responder #(
   parameter int ADDR_W       = 12,
   parameter int WB_DEPTH     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic   clk,
   input  logic   reset,
   dmem_if.slave  bus
);
   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WB_DEPTH);

   logic [31:0]       mem_r [2**ADDR_W];
   logic [ADDR_W-1:0] wb_idx_r  [WB_DEPTH];
   logic [31:0]       wb_data_r [WB_DEPTH];
   logic [PTR_W-1:0]  head_r, tail_r;
   logic [CNT_W-1:0]  count_r;
   logic [31:0]       rd_data_r;
   logic              rd_valid_r;

   logic [ADDR_W-1:0] rd_idx_s, wr_idx_s;
   logic              full_s, force_drain_s, stop_s;
   logic              load_acc_s, store_acc_s, drain_s;
   logic [31:0]       rd_mux_s;

   assign rd_idx_s = bus.rd_addr[ADDR_W+1:2];
   assign wr_idx_s = bus.wr_addr[ADDR_W+1:2];

   logic unused_addr_s;
   assign unused_addr_s = ^{bus.rd_addr[31:ADDR_W+2], bus.rd_addr[1:0],
                            bus.wr_addr[31:ADDR_W+2], bus.wr_addr[1:0]};

`ifdef DMEM_STARVE_GUARD_EN
   localparam int ST_W = $clog2(STARVE_LIMIT + 1);
   logic [ST_W-1:0] starve_r;

   // Starvation counter: counts load-blocked cycles while stores wait
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_r <= '0;
      end else if (drain_s || (count_r == '0)) begin
         starve_r <= '0;
      end else if (bus.rd_en) begin
         starve_r <= starve_r + ST_W'(1);
      end else begin
         starve_r <= starve_r;
      end
   end

   assign force_drain_s = (starve_r >= ST_W'(STARVE_LIMIT));
`else
   localparam int UNUSED_STARVE_LIMIT = STARVE_LIMIT;
   assign force_drain_s = 1'b0;
`endif

   // Port arbitration: a stall blocks load and store together; loads own the RAM port
   always_comb begin
      full_s      = (count_r == CNT_FULL);
      stop_s      = force_drain_s | (bus.is_mem_write & full_s);
      load_acc_s  = bus.rd_en & ~stop_s;
      store_acc_s = bus.is_mem_write & ~stop_s;
      drain_s     = (count_r != '0) & (force_drain_s | ~bus.rd_en);
   end

   assign bus.stop = stop_s;

   // Load data source: same-cycle store beats youngest buffered match beats RAM
   always_comb begin
      logic [PTR_W-1:0] pos_v;
      rd_mux_s = mem_r[rd_idx_s];
      pos_v    = head_r;
      for (int i = 0; i < WB_DEPTH; i++) begin
         pos_v = head_r + PTR_W'(i);
         if ((CNT_W'(i) < count_r) && (wb_idx_r[pos_v] == rd_idx_s)) begin
            rd_mux_s = wb_data_r[pos_v];
         end else begin
            rd_mux_s = rd_mux_s;
         end
      end
      if (store_acc_s && (wr_idx_s == rd_idx_s)) begin
         rd_mux_s = bus.wr_data;
      end else begin
         rd_mux_s = rd_mux_s;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         if (store_acc_s) tail_r <= tail_r + PTR_ONE;
         if (drain_s)     head_r <= head_r + PTR_ONE;
         case ({store_acc_s, drain_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Buffer entry storage
   always_ff @(posedge clk) begin
      if (store_acc_s) begin
         wb_idx_r[tail_r]  <= wr_idx_s;
         wb_data_r[tail_r] <= bus.wr_data;
      end
   end

   // RAM write port, fed only by drains
   always_ff @(posedge clk) begin
      if (drain_s) begin
         mem_r[wb_idx_r[head_r]] <= wb_data_r[head_r];
      end
   end

   // Registered load response
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_r  <= 32'h0000_0000;
         rd_valid_r <= 1'b0;
      end else begin
         rd_valid_r <= load_acc_s;
         if (load_acc_s) rd_data_r <= rd_mux_s;
      end
   end

   assign bus.rd_data  = rd_data_r;
   assign bus.rd_valid = rd_valid_r;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WB_DEPTH=4, STARVE_LIMIT=8).
module tb_dmem_responder;
   logic clk = 1'b0;
   logic reset;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   dmem_if bus ();

   dmem_responder #(.ADDR_W(12), .WB_DEPTH(4), .STARVE_LIMIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic re, input logic [31:0] ra, input logic we,
                        input logic [31:0] wa, input logic [31:0] wd);
      bus.rd_en        = re;
      bus.rd_addr      = ra;
      bus.is_mem_write = we;
      bus.wr_addr      = wa;
      bus.wr_data      = wd;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick;
      chk("reset_rd_data", bus.rd_data, 32'h0);
      chk("reset_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      // store request during reset must not stall
      drive(1'b0, 32'h0, 1'b1, 32'h14, 32'hDEAD_BEEF);
      chk("reset_stop", {31'h0, bus.stop}, 32'h0);
      reset = 1'b1;
      tick;                                   // preload store accepted
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick;                                   // drained to RAM[5]

      // load idx 5 with ignored upper/low address bits
      drive(1'b1, 32'h0000_4017, 1'b0, 32'h0, 32'h0);
      tick;
      chk("load5_valid", {31'h0, bus.rd_valid}, 32'h1);
      chk("load5_data", bus.rd_data, 32'hDEAD_BEEF);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick;
      chk("idle_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk("idle_hold", bus.rd_data, 32'hDEAD_BEEF);

      // same-cycle store/load write-first
      drive(1'b1, 32'h20, 1'b1, 32'h20, 32'h1111_1111);
      chk("wf_stop", {31'h0, bus.stop}, 32'h0);
      tick;
      chk("wf_data", bus.rd_data, 32'h1111_1111);
      chk("wf_valid", {31'h0, bus.rd_valid}, 32'h1);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick;

      // two stores to idx 8, youngest forwarded, FIFO drain order
      drive(1'b1, 32'h20, 1'b1, 32'h20, 32'hA);
      tick;
      chk("st8a", bus.rd_data, 32'hA);
      drive(1'b1, 32'h20, 1'b1, 32'h20, 32'hB);
      tick;
      chk("st8b", bus.rd_data, 32'hB);
      drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
      tick;
      chk("fwd8_1", bus.rd_data, 32'hB);
      tick;
      chk("fwd8_2", bus.rd_data, 32'hB);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      tick;
      tick;
      drive(1'b1, 32'h20, 1'b0, 32'h0, 32'h0);
      tick;
      chk("ram8", bus.rd_data, 32'hB);

      // fill buffer with loads held high
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'h14, 1'b1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i));
         chk($sformatf("fill%0d_stop", i), {31'h0, bus.stop}, 32'h0);
         tick;
         chk($sformatf("fill%0d_data", i), bus.rd_data, 32'hDEAD_BEEF);
      end
      drive(1'b1, 32'h14, 1'b1, 32'h50, 32'h104);
      chk("full_stop", {31'h0, bus.stop}, 32'h1);
      tick;
      chk("full_load_blocked", {31'h0, bus.rd_valid}, 32'h0);
      drive(1'b0, 32'h0, 1'b1, 32'h50, 32'h104);
      chk("no_bypass_stop", {31'h0, bus.stop}, 32'h1);
      tick;                                   // drain, count 4->3
      chk("retry_stop", {31'h0, bus.stop}, 32'h0);
      tick;                                   // 5th store accepted
      drive(1'b1, 32'h50, 1'b0, 32'h0, 32'h0);
      tick;
      chk("fwd_idx20", bus.rd_data, 32'h104);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      repeat (4) tick;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 32'h0, 32'h0);
         tick;
         chk($sformatf("ram%0d", 16 + i), bus.rd_data, 32'h100 + 32'(i));
      end

      // async reset with 3 buffered stores: stores lost
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h14, 1'b1, 32'h40 + 32'(4 * i), 32'hBAD0 + 32'(i));
         tick;
      end
      drive(1'b1, 32'h14, 1'b1, 32'h4C, 32'hBAD3);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk("async_rd_data", bus.rd_data, 32'h0);
      chk("async_stop", {31'h0, bus.stop}, 32'h0);
      drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
      #1;
      reset = 1'b1;
      tick;
      tick;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 32'h0, 32'h0);
         tick;
         chk($sformatf("lost%0d", i), bus.rd_data, 32'h100 + 32'(i));
      end

`ifdef DMEM_STARVE_GUARD_EN
      // one buffered entry starved by loads; forced drain after 8 cycles
      drive(1'b1, 32'h14, 1'b1, 32'h78, 32'h5A5A_5A5A);
      tick;
      drive(1'b1, 32'h14, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("starve%0d_stop", k), {31'h0, bus.stop}, 32'h0);
         tick;
         chk($sformatf("starve%0d_valid", k), {31'h0, bus.rd_valid}, 32'h1);
      end
      chk("force_stop", {31'h0, bus.stop}, 32'h1);
      tick;
      chk("force_valid", {31'h0, bus.rd_valid}, 32'h0);
      chk("after_force_stop", {31'h0, bus.stop}, 32'h0);
      drive(1'b1, 32'h78, 1'b0, 32'h0, 32'h0);
      tick;
      chk("force_ram30", bus.rd_data, 32'h5A5A_5A5A);
`endif

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
